// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_muldiv_ctrl_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer: op codes,
//   FSM states, iteration-core mode and small op-classification helpers.
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_ACC  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    // MULT/MULTU/DIV/DIVU
    function automatic logic is_muldiv(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_madd(input op_e op);
        return (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Ops whose operands are treated as two's complement
    function automatic logic is_signed_op(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_iter_core.sv
// hilo_iter_core
//   One combinational radix-2 step of the iterative multiply/divide.
//   MODE_MUL : shift-add. acc = {partial product, remaining multiplier bits};
//              adds opnd_in into the upper half when acc[0] is set, then
//              shifts the whole (carry,hi,lo) right by one.
//   MODE_DIV : restoring divide. acc = {partial remainder, dividend/quotient};
//              shifts left by one, trial-subtracts opnd_in from the upper
//              part and shifts the quotient bit into the bottom.
// Ports
//   acc_in   in   2*WIDTH  current {hi,lo} working value
//   opnd_in  in   WIDTH    multiplicand or divisor (magnitude)
//   mode_in  in   mode_e   multiply or divide step
//   acc_out  out  2*WIDTH  next {hi,lo} working value
module hilo_iter_core
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   opnd_in,
    input  mode_e              mode_in,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                  + (acc_in[0] ? {1'b0, opnd_in} : '0);
        // Remainder shifted left with the next dividend bit brought in.
        // Since rem < divisor, this fits in WIDTH+1 bits and bit WIDTH of the
        // difference is a clean borrow flag.
        div_trial = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_in};
        acc_out   = '0;
        if (mode_in == MODE_MUL) begin
            acc_out = {mul_sum, acc_in[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_out = {div_trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {acc_in[2*WIDTH-2:WIDTH-1], acc_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Multi-cycle sequencer for the HI/LO multiply/divide resource. Accepts
//   MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs an iterative radix-2 core
//   for WIDTH cycles, applies the sign fix-up and owns the HI/LO registers.
//   Optional feature macro: HILO_MADD_EN enables MADD/MSUB (signed multiply
//   followed by a one-cycle accumulate into {HI,LO}); without it ops 110/111
//   are NOPs.
// Ports
//   Clk        in   1      system clock, rising edge
//   Rst_n      in   1      asynchronous active-low reset
//   Start_in   in   1      EX-stage HI/LO op valid
//   Op_in      in   3      op code (see op_e)
//   A_in       in   WIDTH  rs operand
//   B_in       in   WIDTH  rt operand
//   MfReq_in   in   1      ID/EX holds MFHI/MFLO
//   Flush_in   in   1      pipeline flush, aborts an in-flight op
//   Busy_out   out  1      iterative op in flight
//   Stall_out  out  1      Busy_out & (Start_in | MfReq_in)
//   Done_out   out  1      one-cycle pulse when an iterative op writes HI/LO
//   Hi_out     out  WIDTH  HI register
//   Lo_out     out  WIDTH  LO register
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start_in,
    input  logic [2:0]       Op_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             MfReq_in,
    input  logic             Flush_in,
    output logic             Busy_out,
    output logic             Stall_out,
    output logic             Done_out,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out
);

`ifdef HILO_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e               state, state_nxt;
    op_e                  op_in_e;
    op_e                  op_q;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_raw;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    logic                 accept;
    logic                 start_iter;
    logic                 signed_in;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 madd_q;
    mode_e                core_mode;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;
    logic [2*WIDTH-1:0]   hilo_sum, hilo_diff;

    assign op_in_e = op_e'(Op_in);

    // Flush in IDLE suppresses acceptance; Start while busy is never seen here
    always_comb begin
        accept     = (state == ST_IDLE) && Start_in && !Flush_in;
        start_iter = accept && (is_muldiv(op_in_e) || (MADD_EN && is_madd(op_in_e)));
        signed_in  = is_signed_op(op_in_e);
        a_mag      = (signed_in && A_in[WIDTH-1]) ? -A_in : A_in;
        b_mag      = (signed_in && B_in[WIDTH-1]) ? -B_in : B_in;
        madd_q     = MADD_EN && is_madd(op_q);
        core_mode  = is_div(op_q) ? MODE_DIV : MODE_MUL;
    end

    hilo_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .acc_in  (acc),
        .opnd_in (opnd),
        .mode_in (core_mode),
        .acc_out (acc_step)
    );

    // Sign fix-up on the raw magnitude result. The -2^(W-1)/-1 case needs
    // no special handling: |A|/|B| = 2^(W-1) rem 0 and the signs agree, so
    // the unnegated quotient already reads as the most-negative value.
    always_comb begin
        prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
        if (opnd == '0) begin
            quot_fix = '1;
            rem_fix  = a_raw;
        end else begin
            quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
        hilo_sum  = {hi_q, lo_q} + acc;
        hilo_diff = {hi_q, lo_q} - acc;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start_iter) state_nxt = ST_RUN;
            ST_RUN: begin
                if (Flush_in)        state_nxt = ST_IDLE;
                else if (cnt == '0)  state_nxt = ST_FIX;
            end
            ST_FIX: begin
                if (Flush_in)        state_nxt = ST_IDLE;
                else if (madd_q)     state_nxt = ST_ACC;
                else                 state_nxt = ST_IDLE;
            end
            ST_ACC:                  state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Busy_out  = (state != ST_IDLE);
        Stall_out = Busy_out && (Start_in || MfReq_in);
        Done_out  = done_q;
        Hi_out    = hi_q;
        Lo_out    = lo_q;
    end

    // ---------------- Datapath: counter, working regs, HI/LO ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_q   <= OP_MULT;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_iter) begin
                        op_q   <= op_in_e;
                        sign_a <= signed_in && A_in[WIDTH-1];
                        sign_b <= signed_in && B_in[WIDTH-1];
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        opnd   <= b_mag;
                        a_raw  <= A_in;
                        cnt    <= CW'(WIDTH - 1);
                    end else if (accept && (op_in_e == OP_MTHI)) begin
                        hi_q <= A_in;
                    end else if (accept && (op_in_e == OP_MTLO)) begin
                        lo_q <= A_in;
                    end
                end
                ST_RUN: begin
                    if (!Flush_in) begin
                        acc <= acc_step;
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!Flush_in) begin
                        if (madd_q) begin
                            // Hand the signed product to the ACC cycle
                            acc <= prod_fix;
                        end else begin
                            if (is_div(op_q)) begin
                                hi_q <= rem_fix;
                                lo_q <= quot_fix;
                            end else begin
                                {hi_q, lo_q} <= prod_fix;
                            end
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (!Flush_in) begin
                        {hi_q, lo_q} <= (op_q == OP_MSUB) ? hilo_diff : hilo_sum;
                        done_q       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

    localparam int unsigned W = 32;
`ifdef HILO_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Start_in = 1'b0;
    logic [2:0]   Op_in = 3'd0;
    logic [W-1:0] A_in = '0;
    logic [W-1:0] B_in = '0;
    logic         MfReq_in = 1'b0;
    logic         Flush_in = 1'b0;
    logic         Busy_out, Stall_out, Done_out;
    logic [W-1:0] Hi_out, Lo_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start_in  (Start_in),
        .Op_in     (Op_in),
        .A_in      (A_in),
        .B_in      (B_in),
        .MfReq_in  (MfReq_in),
        .Flush_in  (Flush_in),
        .Busy_out  (Busy_out),
        .Stall_out (Stall_out),
        .Done_out  (Done_out),
        .Hi_out    (Hi_out),
        .Lo_out    (Lo_out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Architectural reference: plain 64-bit arithmetic on the MIPS rules
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        logic [63:0]     cat;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); {exp_hi, exp_lo} = sp; end
            3'd1: begin up = 64'(a) * 64'(b); {exp_hi, exp_lo} = up; end
            3'd2: begin
                if (b == 0) begin exp_hi = a; exp_lo = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000; exp_hi = '0;
                end else begin exp_lo = sa / sb; exp_hi = sa % sb; end
            end
            3'd3: begin
                if (b == 0) begin exp_hi = a; exp_lo = '1; end
                else begin exp_lo = a / b; exp_hi = a % b; end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: begin
                if (MADD) begin
                    sp  = longint'(sa) * longint'(sb);
                    cat = {exp_hi, exp_lo};
                    cat = (op == 3'd6) ? cat + sp : cat - sp;
                    {exp_hi, exp_lo} = cat;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mf, input string tag);
        bit iter, seen;
        int lat, busy_n, stall_n, extra;
        iter  = (op < 3'd4) || (MADD && op >= 3'd6);
        extra = (MADD && op >= 3'd6) ? 1 : 0;
        @(negedge Clk);
        Start_in = 1'b1; Op_in = op; A_in = a; B_in = b; MfReq_in = mf;
        model(op, a, b);
        @(posedge Clk); #1;
        Start_in = 1'b0;
        if (iter) begin
            lat = 0; busy_n = 0; stall_n = 0; seen = 0;
            while (!seen && lat < 200) begin
                @(negedge Clk);
                lat++;
                if (Done_out === 1'b1) seen = 1;
                else begin
                    if (Busy_out === 1'b1)  busy_n++;
                    if (Stall_out === 1'b1) stall_n++;
                end
            end
            chk({tag, "_done_seen"}, 64'(seen), 64'd1);
            chk({tag, "_latency"}, 64'(lat), 64'(W + 2 + extra));
            chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1 + extra));
            if (mf) begin
                chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(W + 1 + extra));
                chk({tag, "_stall_on_done"}, 64'(Stall_out), 64'd0);
            end
            chk({tag, "_hi"}, 64'(Hi_out), 64'(exp_hi));
            chk({tag, "_lo"}, 64'(Lo_out), 64'(exp_lo));
            @(negedge Clk);
            chk({tag, "_done_pulse"}, 64'(Done_out), 64'd0);
        end else begin
            @(negedge Clk);
            chk({tag, "_busy"}, 64'(Busy_out), 64'd0);
            chk({tag, "_done"}, 64'(Done_out), 64'd0);
            chk({tag, "_hi"}, 64'(Hi_out), 64'(exp_hi));
            chk({tag, "_lo"}, 64'(Lo_out), 64'(exp_lo));
        end
        MfReq_in = 1'b0;
    endtask

    initial begin
        int          dn, stall_n, guard;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        // Reset state
        #12;
        chk("rst_busy", 64'(Busy_out), 64'd0);
        chk("rst_done", 64'(Done_out), 64'd0);
        chk("rst_hi", 64'(Hi_out), 64'd0);
        chk("rst_lo", 64'(Lo_out), 64'd0);
        MfReq_in = 1'b1; Start_in = 1'b1; #1;
        chk("rst_stall", 64'(Stall_out), 64'd0);
        MfReq_in = 1'b0; Start_in = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;

        // Directed arithmetic cases
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg3x5");
        chk("mult_neg3x5_hi_const", 64'(Hi_out), 64'hFFFF_FFFF);
        chk("mult_neg3x5_lo_const", 64'(Lo_out), 64'hFFFF_FFF1);
        run_op(3'd3, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(3'd3, 32'd9, 32'd0, 1'b0, "divu_by0");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_by0_signed");
        run_op(3'd1, 32'd6, 32'd7, 1'b1, "multu_mfreq");
        chk("multu_lo42", 64'(Lo_out), 64'd42);

        // MTHI, then flush a MULT mid-flight
        run_op(3'd4, 32'h1234, 32'd0, 1'b0, "mthi");
        @(negedge Clk);
        Start_in = 1'b1; Op_in = 3'd0; A_in = 32'd5; B_in = 32'd7;
        @(posedge Clk); #1;
        Start_in = 1'b0;
        repeat (10) @(negedge Clk);
        Flush_in = 1'b1;
        @(posedge Clk); #1;
        Flush_in = 1'b0;
        @(negedge Clk);
        chk("flush_busy_drop", 64'(Busy_out), 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done_out === 1'b1) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        chk("flush_hi_kept", 64'(Hi_out), 64'h1234);
        chk("flush_lo_kept", 64'(Lo_out), 64'(exp_lo));

        // Flush and Start together in IDLE: start ignored
        @(negedge Clk);
        Start_in = 1'b1; Flush_in = 1'b1; Op_in = 3'd4; A_in = 32'hDEAD;
        @(posedge Clk); #1;
        Start_in = 1'b0; Flush_in = 1'b0;
        @(negedge Clk);
        chk("flush_start_hi", 64'(Hi_out), 64'h1234);
        chk("flush_start_busy", 64'(Busy_out), 64'd0);

        // Start held while busy: stalled, not accepted; taken on the Done cycle
        @(negedge Clk);
        Start_in = 1'b1; Op_in = 3'd3; A_in = 32'd1000; B_in = 32'd33;
        model(3'd3, 32'd1000, 32'd33);
        @(posedge Clk); #1;
        Op_in = 3'd5; A_in = 32'hCAFE;
        stall_n = 0; guard = 0;
        @(negedge Clk);
        while (Done_out !== 1'b1 && guard < 200) begin
            if (Stall_out === 1'b1) stall_n++;
            @(negedge Clk);
            guard++;
        end
        chk("hold_stall_cycles", 64'(stall_n), 64'(W + 1));
        chk("hold_lo_quot", 64'(Lo_out), 64'(exp_lo));
        chk("hold_hi_rem", 64'(Hi_out), 64'(exp_hi));
        model(3'd5, 32'hCAFE, 32'd0);
        @(posedge Clk); #1;
        Start_in = 1'b0;
        @(negedge Clk);
        chk("b2b_mtlo", 64'(Lo_out), 64'(exp_lo));
        chk("b2b_busy", 64'(Busy_out), 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", i, rop));
        end

        // MADD accumulate (NOP without the feature)
        run_op(3'd4, 32'd0, 32'd0, 1'b0, "madd_pre_hi");
        run_op(3'd5, 32'd10, 32'd0, 1'b0, "madd_pre_lo");
        run_op(3'd6, 32'd3, 32'd4, 1'b0, "madd_3x4");
        chk("madd_lo_const", 64'(Lo_out), MADD ? 64'd22 : 64'd10);

        // Asynchronous reset in the middle of a DIV
        run_op(3'd4, 32'h5555, 32'd0, 1'b0, "pre_rst_hi");
        @(negedge Clk);
        Start_in = 1'b1; Op_in = 3'd2; A_in = 32'd12345; B_in = 32'd7;
        @(posedge Clk); #1;
        Start_in = 1'b0; MfReq_in = 1'b1;
        repeat (20) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(Busy_out), 64'd0);
        chk("arst_stall", 64'(Stall_out), 64'd0);
        chk("arst_done", 64'(Done_out), 64'd0);
        chk("arst_hi", 64'(Hi_out), 64'd0);
        chk("arst_lo", 64'(Lo_out), 64'd0);
        MfReq_in = 1'b0;
        exp_hi = '0; exp_lo = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "post_rst_multu");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
